// File: rtl/ifetch_unit.sv
// Instruction fetch stage: req/ack fetch from instruction memory into the IF/ID register,
// with a one-entry skid buffer for decode back-pressure and redirect (flush) handling.
module ifetch_unit #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] PC_BASE = 32'h0000_3000,
  parameter logic [DATA_W-1:0] NOP     = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc,
  output logic              stallF,
  input  logic              flush,
  input  logic              stall_d,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_pc,
  output logic              if_valid
);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] if_instr_reg, if_instr_next;
  logic [DATA_W-1:0] if_pc_reg, if_pc_next;
  logic              if_valid_reg, if_valid_next;
  logic [DATA_W-1:0] skid_instr_reg, skid_instr_next;
  logic [DATA_W-1:0] skid_pc_reg, skid_pc_next;
  logic [DATA_W-1:0] addr_q_reg;

  logic              load;
  logic [DATA_W-1:0] load_instr, load_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      if_instr_reg   <= NOP;
      if_pc_reg      <= PC_BASE;
      if_valid_reg   <= 1'b0;
      skid_instr_reg <= NOP;
      skid_pc_reg    <= PC_BASE;
      addr_q_reg     <= PC_BASE;
    end else begin
      state_reg      <= state_next;
      if_instr_reg   <= if_instr_next;
      if_pc_reg      <= if_pc_next;
      if_valid_reg   <= if_valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
      if (state_reg == REQ) begin
        addr_q_reg <= pc;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;
    load            = 1'b0;
    load_instr      = imem_rdata;
    load_pc         = pc;

    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (flush) begin
          // A flush coinciding with ack simply discards the response.
          if (!imem_ack) begin
            state_next = DROP;
          end
        end else if (imem_ack) begin
          if (!if_valid_reg || !stall_d) begin
            load = 1'b1;
          end else begin
            skid_instr_next = imem_rdata;
            skid_pc_next    = pc;
            state_next      = HOLD;
          end
        end
      end
      DROP: begin
        if (!flush && imem_ack) begin
          state_next = REQ;
        end
      end
      HOLD: begin
        if (flush) begin
          skid_instr_next = NOP;
          skid_pc_next    = PC_BASE;
          state_next      = REQ;
        end else if (!stall_d) begin
          load       = 1'b1;
          load_instr = skid_instr_reg;
          load_pc    = skid_pc_reg;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // IF/ID register: flush beats a new load, which beats a decode stall; otherwise a bubble.
  always_comb begin
    if_instr_next = if_instr_reg;
    if_pc_next    = if_pc_reg;
    if_valid_next = 1'b0;
    if (flush) begin
      if_instr_next = NOP;
    end else if (load) begin
      if_instr_next = load_instr;
      if_pc_next    = load_pc;
      if_valid_next = 1'b1;
    end else if (stall_d && if_valid_reg) begin
      if_valid_next = 1'b1;
    end
  end

  // The in-flight address is frozen while a dropped request is still outstanding.
  assign imem_req  = !rst && ((state_reg == REQ) || (state_reg == DROP));
  assign imem_addr = (state_reg == DROP) ? addr_q_reg : pc;
  assign stallF    = rst ? 1'b1 :
                     flush ? 1'b0 :
                     ((state_reg == REQ) && imem_ack) ? 1'b0 : 1'b1;

  assign if_instr = if_instr_reg;
  assign if_pc    = if_pc_reg;
  assign if_valid = if_valid_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: PC register and wait-state memory models around the DUT, a
// queue-based reference of the fetch stage checked every cycle, plus directed literal checks.
module tb_ifetch_unit;

  localparam logic [31:0] PC_BASE = 32'h0000_3000;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        stallF;
  logic        flush = 1'b0;
  logic        stall_d = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;

  int          checks = 0;
  int          errors = 0;
  int          wait_n = 0;
  int          cnt;
  logic [31:0] target = 32'h0;

  always #5 clk = ~clk;

  ifetch_unit #(.DATA_W(32), .PC_BASE(PC_BASE), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .stallF(stallF), .flush(flush), .stall_d(stall_d),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid)
  );

  // PC register: advances by 4 or loads the redirect target whenever not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= PC_BASE;
    else if (!stallF) pc <= flush ? target : pc + 32'd4;
  end

  // Memory: acks after wait_n cycles of continuous request; data derived from the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (imem_req && !imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end
  assign imem_ack   = imem_req && (cnt >= wait_n);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: IF/ID plus skid seen as a queue of at most two fetched entries.
  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} ent_t;
  ent_t        q[$];
  bit          started, dropping, req_m, resp;
  logic [31:0] drop_addr, show_instr, show_pc;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_stallF", {31'b0, stallF}, 32'd1);
      chk("rst_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_instr", if_instr, NOP);
      chk("rst_pc", if_pc, PC_BASE);
      q.delete();
      started = 0; dropping = 0;
      drop_addr = PC_BASE; show_instr = NOP; show_pc = PC_BASE;
    end else begin
      req_m = started && (dropping || q.size() < 2);
      chk("req", {31'b0, imem_req}, {31'b0, req_m});
      chk("addr", imem_addr, dropping ? drop_addr : pc);
      chk("stallF", {31'b0, stallF},
          {31'b0, !(flush || (req_m && !dropping && imem_ack))});
      chk("valid", {31'b0, if_valid}, {31'b0, q.size() != 0});
      chk("instr", if_instr, show_instr);
      chk("if_pc", if_pc, show_pc);
      if (if_valid && !stall_d)
        $display("decode takes pc=%h instr=%h at %0t", if_pc, if_instr, $time);
      if (flush) begin
        if (req_m && !dropping && !imem_ack) begin
          dropping  = 1;
          drop_addr = imem_addr;
        end
        q.delete();
        show_instr = NOP;
      end else begin
        resp = req_m && !dropping && imem_ack;
        if (dropping && imem_ack) dropping = 0;
        if (q.size() > 0 && !stall_d) void'(q.pop_front());
        if (resp) q.push_back('{instr: imem_rdata, pc: pc});
        if (q.size() > 0) begin
          show_instr = q[0].instr;
          show_pc    = q[0].pc;
        end
      end
      started = 1;
    end
  end

  task automatic cyc(input logic f, input logic s, input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      flush   = f;
      stall_d = s;
    end
  endtask

  task automatic do_reset(input int w);
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; stall_d = 1'b0; wait_n = w;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // Zero-wait streaming
    do_reset(0);
    @(negedge clk); chk("A1_req", {31'b0, imem_req}, 32'd0);
    cyc(0, 0); @(negedge clk);
    chk("A2_req", {31'b0, imem_req}, 32'd1);
    chk("A2_stallF", {31'b0, stallF}, 32'd0);
    chk("A2_addr", imem_addr, 32'h3000);
    cyc(0, 0); @(negedge clk);
    chk("A3_valid", {31'b0, if_valid}, 32'd1);
    chk("A3_pc", if_pc, 32'h3000);
    chk("A3_instr", if_instr, 32'hA5A5_3000);
    cyc(0, 0); @(negedge clk); chk("A4_pc", if_pc, 32'h3004);
    cyc(0, 0, 4);

    // Two wait states
    do_reset(2);
    cyc(0, 0, 2); @(negedge clk);
    chk("B3_stallF", {31'b0, stallF}, 32'd1);
    chk("B3_addr", imem_addr, 32'h3000);
    cyc(0, 0); @(negedge clk); chk("B4_stallF", {31'b0, stallF}, 32'd0);
    cyc(0, 0); @(negedge clk);
    chk("B5_valid", {31'b0, if_valid}, 32'd1);
    chk("B5_pc", if_pc, 32'h3000);
    cyc(0, 0); @(negedge clk); chk("B6_valid", {31'b0, if_valid}, 32'd0);
    cyc(0, 0, 2); @(negedge clk);
    chk("B8_valid", {31'b0, if_valid}, 32'd1);
    chk("B8_instr", if_instr, 32'hA5A5_3004);
    cyc(0, 0, 3);

    // Decode stall into skid, then flush in HOLD
    do_reset(0);
    cyc(0, 0);
    cyc(0, 1); @(negedge clk); chk("C3_pc", if_pc, 32'h3000);
    cyc(0, 1); @(negedge clk);
    chk("C4_req", {31'b0, imem_req}, 32'd0);
    chk("C4_pc", if_pc, 32'h3000);
    cyc(0, 1);
    cyc(0, 0); @(negedge clk);
    chk("C6_req", {31'b0, imem_req}, 32'd0);
    chk("C6_pc", if_pc, 32'h3000);
    cyc(0, 0); @(negedge clk);
    chk("C7_pc", if_pc, 32'h3004);
    chk("C7_instr", if_instr, 32'hA5A5_3004);
    cyc(0, 0); @(negedge clk); chk("C8_pc", if_pc, 32'h3008);
    cyc(0, 1); @(negedge clk); chk("C9_pc", if_pc, 32'h300C);
    target = 32'h3200;
    cyc(1, 1); @(negedge clk); chk("C10_req", {31'b0, imem_req}, 32'd0);
    cyc(0, 0); @(negedge clk);
    chk("C11_valid", {31'b0, if_valid}, 32'd0);
    chk("C11_instr", if_instr, NOP);
    chk("C11_addr", imem_addr, 32'h3200);
    cyc(0, 0); @(negedge clk); chk("C12_pc", if_pc, 32'h3200);
    cyc(0, 0, 2);

    // Three wait states: flush while in flight, then flush coinciding with ack
    do_reset(3);
    cyc(0, 0, 8); @(negedge clk); chk("D9_addr", imem_addr, 32'h3004);
    cyc(0, 1); @(negedge clk);
    chk("D10_pc", if_pc, 32'h3004);
    chk("D10_addr", imem_addr, 32'h3008);
    target = 32'h3100;
    cyc(1, 1); @(negedge clk); chk("D11_stallF", {31'b0, stallF}, 32'd0);
    cyc(0, 0); @(negedge clk);
    chk("D12_addr", imem_addr, 32'h3008);
    chk("D12_valid", {31'b0, if_valid}, 32'd0);
    chk("D12_instr", if_instr, NOP);
    cyc(0, 0); @(negedge clk);
    chk("D13_addr", imem_addr, 32'h3008);
    chk("D13_stallF", {31'b0, stallF}, 32'd1);
    cyc(0, 0); @(negedge clk);
    chk("D14_addr", imem_addr, 32'h3100);
    chk("D14_valid", {31'b0, if_valid}, 32'd0);
    cyc(0, 0, 3); @(negedge clk); chk("D17_valid", {31'b0, if_valid}, 32'd0);
    cyc(0, 1); @(negedge clk);
    chk("D18_pc", if_pc, 32'h3100);
    chk("D18_instr", if_instr, 32'hA5A5_3100);
    cyc(0, 1, 2);
    target = 32'h3300;
    cyc(1, 1); @(negedge clk); chk("D21_valid", {31'b0, if_valid}, 32'd1);
    cyc(0, 0); @(negedge clk);
    chk("D22_valid", {31'b0, if_valid}, 32'd0);
    chk("D22_addr", imem_addr, 32'h3300);
    chk("D22_req", {31'b0, imem_req}, 32'd1);
    cyc(0, 0, 4); @(negedge clk); chk("D26_pc", if_pc, 32'h3300);

    // Asynchronous reset mid-request
    do_reset(0);
    cyc(0, 0, 3);
    @(posedge clk); #2;
    chk("E_req_before", {31'b0, imem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("E_req", {31'b0, imem_req}, 32'd0);
    chk("E_valid", {31'b0, if_valid}, 32'd0);
    chk("E_pc", if_pc, 32'h3000);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Fetch-side consumer of the PC register. Reads the current `pc`, drives a req/ack handshake to instruction memory, and loads the IF/ID pipeline register (`if_instr`/`if_pc`/`if_valid`). It generates `stallF` back to the PC register and absorbs decode back-pressure with a one-entry skid buffer. It handles branch/jump redirects (`flush`), including a response that is already in flight.

Parameters:
DATA_W, 32, instruction and address width.
PC_BASE, 32'h0000_3000, reset value of `if_pc` and skid PC; matches the PC reset vector.
NOP, 32'h0000_0000, value of `if_instr` and skid instruction on reset and flush.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
pc  in  DATA_W  current PC; registered in the PC block, updates only when `stallF`=0.
stallF  out  1  combinational; 1 holds the PC register.
flush  in  1  redirect this cycle; the PC block loads the target at this edge.
stall_d  in  1  decode cannot accept a new IF/ID entry.
imem_req  out  1  fetch request.
imem_addr  out  DATA_W  fetch address.
imem_rdata  in  DATA_W  instruction; valid when `imem_ack`=1.
imem_ack  in  1  response strobe; may coincide with the first `imem_req` cycle (zero-wait memory).
if_instr  out  DATA_W  IF/ID instruction.
if_pc  out  DATA_W  IF/ID PC.
if_valid  out  1  IF/ID entry valid.

Behaviour:
- Reset, asynchronous: state=IDLE, `if_valid`=0, `if_instr`=NOP, `if_pc`=PC_BASE, skid cleared, `addr_q`=PC_BASE.
- Reset effect on outputs: `imem_req`=0 and `stallF`=1 while `rst`=1. Reset asserted mid-request abandons the request immediately; memory must tolerate the dropped request.
- States: IDLE, REQ, DROP, HOLD.
- `imem_req`: 1 in REQ and DROP; 0 in IDLE and HOLD.
- `imem_addr`: `addr_q` in DROP, else `pc`.
- `addr_q`: loaded with `pc` on every clock edge in REQ.
- `stallF`: 0 if `flush`=1; else 0 in REQ with `imem_ack`=1; else 1. Consequence: `pc` is stable while a REQ is outstanding.
- Transitions with `flush`=1 (highest priority):
  - IDLE→REQ.
  - REQ without ack→DROP.
  - REQ with ack: response discarded, stay REQ.
  - DROP→DROP.
  - HOLD→REQ, skid cleared.
- IDLE, no flush: →REQ after one cycle. First `imem_req` occurs in the 2nd cycle after reset release.
- REQ, ack, no flush:
  - If `if_valid`=0 or `stall_d`=0: `if_instr`←`imem_rdata`, `if_pc`←`pc`, `if_valid`←1, stay REQ.
  - Else: skid←(`imem_rdata`, `pc`), →HOLD.
- REQ, no ack, no flush: hold.
- DROP, ack: response discarded, →REQ; the next request uses the redirected `pc`.
- DROP, no ack: hold; address stays `addr_q`, so the in-flight address is never changed.
- HOLD, `stall_d`=0: IF/ID←skid, `if_valid`←1, →REQ.
- HOLD, `stall_d`=1: hold.
- IF/ID register update priority:
  1. `flush` → `if_valid`←0, `if_instr`←NOP.
  2. New load as above.
  3. `stall_d`=1 with `if_valid`=1 → hold.
  4. Otherwise `if_valid`←0 (bubble).
- Throughput: one instruction per cycle with zero-wait memory; with N wait cycles, one per N+1 cycles.
- No responses are lost or duplicated across `stall_d`/`flush` combinations. The IF/ID register never shows a pre-flush instruction after a flush edge.

Test Plan:
- Zero-wait memory (ack = req), `pc` sequence 0x3000, 0x3004, 0x3008 → first `if_valid`=1 in the 3rd cycle after reset release with `if_pc`=0x3000; then one instruction per cycle; `stallF`=0 every REQ cycle.
- Two-wait-state memory → `stallF`=1 for 2 cycles per fetch; `imem_addr` stable; `if_valid` pulses once every 3 cycles.
- `stall_d`=1 for 3 cycles while `if_valid`=1 and ack arrives → skid holds the instruction, HOLD with `imem_req`=0. After release, `if_instr` shows the held instruction, then the next fetch; no loss, no duplication.
- `flush` with target 0x3100 while a 3-wait request to 0x3008 is in flight → DROP; `imem_addr` stays 0x3008 until ack; that response is discarded; next request is 0x3100; `if_valid`=0 from the flush edge until the 0x3100 instruction arrives.
- `flush` coinciding with ack in REQ, and `flush` in HOLD → response/skid discarded, `if_valid`=0 next cycle, fetch of the target next cycle.
- Reset asserted asynchronously while `imem_req`=1 → `imem_req`=0, `if_valid`=0, `if_pc`=0x3000 without waiting for a clock edge.
